// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: maps the VGA raster to a down-scaled frame-buffer read address,
// expands 3-bit RGB to 8 bits per channel and delays the syncs to match BRAM latency.
module vga_pixel_fetch #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              display_enable_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_data,
  output logic              hsync,
  output logic              vsync,
  output logic              display_enable,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);

  localparam int LAT = RD_LATENCY + 2;
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [9:0] LINE_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [9:0] H_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);

  function automatic logic [7:0] expand_bit(input logic b);
    return {8{b}};
  endfunction

  logic [ADDR_W-1:0] row_base;
  logic [9:0]        h_fb;
  logic              row_clr;
  logic              row_inc;
  logic [LAT-1:0]    hs_dly;
  logic [LAT-1:0]    vs_dly;
  logic [LAT-1:0]    de_dly;
  logic              de_align;
  logic              vs_prev;
  logic              unused_bits;

  assign h_fb        = hcount >> SCALE_SHIFT;
  assign row_clr     = (vcount == V_END);
  assign row_inc     = (hcount == H_END) && (vcount < V_END) &&
                       ((vcount & LINE_MASK) == LINE_MASK);
  assign unused_bits = ^bram_data[7:3];

  // Address stage: row_base steps by one buffer row every 2^SCALE_SHIFT lines
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      row_base  <= '0;
      bram_addr <= '0;
    end else begin
      if (row_clr)
        row_base <= '0;
      else if (row_inc)
        row_base <= row_base + FB_W_A;
      bram_addr <= display_enable_in ? row_base + ADDR_W'(h_fb) : '0;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly <= '1;
      vs_dly <= '1;
      de_dly <= '0;
    end else begin
      hs_dly <= {hs_dly[LAT-2:0], hsync_in};
      vs_dly <= {vs_dly[LAT-2:0], vsync_in};
      de_dly <= {de_dly[LAT-2:0], display_enable_in};
    end
  end

  // Output stage: enable tapped one stage early so it lines up with bram_data
  assign de_align = de_dly[LAT-2];

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
      vs_prev <= 1'b1;
    end else begin
      vga_r   <= de_align ? expand_bit(bram_data[2]) : 8'h00;
      vga_g   <= de_align ? expand_bit(bram_data[1]) : 8'h00;
      vga_b   <= de_align ? expand_bit(bram_data[0]) : 8'h00;
      vs_prev <= vsync;
    end
  end

  assign hsync          = hs_dly[LAT-1];
  assign vsync          = vs_dly[LAT-1];
  assign display_enable = de_dly[LAT-1];
  assign frame_start    = vs_prev & ~vsync;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: sparse raster sweep, mid-frame reset,
// RGB expansion and sync latency against a reference address/colour model.
module tb_vga_pixel_fetch;

  logic        clk_25mhz = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount, vcount;
  logic        de_in, hs_in, vs_in;
  logic [14:0] bram_addr;
  logic [7:0]  bram_data = 8'h00;
  logic        hsync, vsync, display_enable, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_pixel_fetch dut (
    .clk_25mhz(clk_25mhz), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .display_enable_in(de_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .bram_addr(bram_addr), .bram_data(bram_data), .hsync(hsync), .vsync(vsync),
    .display_enable(display_enable), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // BRAM model, one clock read latency, contents = addr[7:0] ^ key
  logic [7:0] key = 8'h00;
  always @(posedge clk_25mhz) bram_data <= bram_addr[7:0] ^ key;

  typedef struct {
    int         due;
    logic [3:0] ctl;
    logic [23:0] rgb;
    bit         rgb_known;
  } out_t;
  typedef struct {
    int          due;
    logic [14:0] addr;
  } addr_t;

  out_t  out_q[$];
  addr_t addr_q[$];
  int    checks = 0;
  int    passes = 0;
  logic  exp_vs_prev = 1'b1;
  bit    addr_known = 1'b1;
  int    de_cnt = 0;
  int    fs_cnt = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic hs_in_d = 1'b1, hs_d = 1'b1;
  int   fall_in = -1;
  bit   lat_done = 1'b0;

  always @(negedge clk_25mhz) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      if (addr_q[0].due < cyc) check_eq("addr_stale", 64'(addr_q[0].due), 64'(cyc));
      else check_eq("bram_addr", 64'(bram_addr), 64'(addr_q[0].addr));
      void'(addr_q.pop_front());
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      if (out_q[0].due < cyc) check_eq("out_stale", 64'(out_q[0].due), 64'(cyc));
      else begin
        check_eq("de_hs_vs_fs", 64'({display_enable, hsync, vsync, frame_start}), 64'(out_q[0].ctl));
        if (out_q[0].rgb_known)
          check_eq("rgb", 64'({vga_r, vga_g, vga_b}), 64'(out_q[0].rgb));
      end
      void'(out_q.pop_front());
    end
    if (reset_n) begin
      de_cnt += int'(display_enable);
      fs_cnt += int'(frame_start);
      if (hs_in_d && !hs_in && fall_in < 0) fall_in = cyc;
      if (hs_d && !hsync && fall_in >= 0 && !lat_done) begin
        check_eq("hsync_latency", 64'(cyc - fall_in), 64'(3));
        lat_done = 1'b1;
      end
    end
    hs_in_d = hs_in;
    hs_d    = hsync;
  end

  task automatic push_out(input int due, input logic de, hs, vs, input logic [23:0] rgb, input bit known);
    out_t o;
    o.due = due;
    o.ctl = {de, hs, vs, exp_vs_prev & ~vs};
    o.rgb = rgb;
    o.rgb_known = known;
    exp_vs_prev = vs;
    out_q.push_back(o);
  endtask

  task automatic step(input int h, input int v, input logic de, input logic hs, input logic vs);
    addr_t a;
    logic [14:0] ea;
    logic [7:0]  d;
    hcount = 10'(h); vcount = 10'(v); de_in = de; hs_in = hs; vs_in = vs;
    ea = de ? 15'((v / 4) * 160 + h / 4) : 15'd0;
    if (!de || addr_known) begin
      a.due = cyc + 1; a.addr = ea;
      addr_q.push_back(a);
    end
    d = ea[7:0] ^ key;
    push_out(cyc + 3, de, hs, vs,
             de ? {{8{d[2]}}, {8{d[1]}}, {8{d[0]}}} : 24'h0, !de || addr_known);
    @(posedge clk_25mhz); #1;
  endtask

  task automatic line(input int v);
    int hl[7] = '{0, 3, 4, 20, 24, 352, 639};
    logic vs;
    vs = !(v == 490 || v == 491);
    if (v < 480) begin
      foreach (hl[i]) step(hl[i], v, 1'b1, 1'b1, vs);
    end else begin
      step(0, v, 1'b0, 1'b1, vs);
    end
    step(640, v, 1'b0, 1'b1, vs);
    step(656, v, 1'b0, 1'b0, vs);
    step(752, v, 1'b0, 1'b1, vs);
    if (v == 480) addr_known = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    out_q.delete();
    addr_q.delete();
    addr_known  = 1'b0;
    exp_vs_prev = 1'b1;
    #2;
    check_eq("rst_sync", 64'({hsync, vsync, display_enable, frame_start}), 64'(4'b1100));
    check_eq("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'(0));
    check_eq("rst_addr", 64'(bram_addr), 64'(0));
    @(posedge clk_25mhz); #1;
    @(posedge clk_25mhz); #1;
    reset_n = 1'b1;
    push_out(cyc + 1, 1'b0, 1'b1, 1'b1, 24'h0, 1'b1);
    push_out(cyc + 2, 1'b0, 1'b1, 1'b1, 24'h0, 1'b1);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(0, 524, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    hcount = 10'd0; vcount = 10'd0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    @(posedge clk_25mhz); #1;
    @(posedge clk_25mhz); #1;
    do_reset();
    addr_known = 1'b1;

    for (int v = 0; v < 525; v++) line(v);
    flush();
    check_eq("frame1_de_count", 64'(de_cnt), 64'(7 * 480));
    check_eq("frame1_fs_count", 64'(fs_cnt), 64'(1));

    for (int v = 0; v < 200; v++) line(v);
    step(0, 200, 1'b1, 1'b1, 1'b1);
    step(3, 200, 1'b1, 1'b1, 1'b1);
    do_reset();
    for (int v = 200; v < 525; v++) line(v);

    for (int v = 0; v < 525; v++) line(v);
    flush();

    key = 8'h07;
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1, 1'b1);
    step(8, 0, 1'b1, 1'b1, 1'b1);
    flush();

    for (int i = 0; i < 10 && (out_q.size() + addr_q.size()) > 0; i++)
      @(posedge clk_25mhz);
    #1;
    check_eq("queue_drain", 64'(out_q.size() + addr_q.size()), 64'(0));
    check_eq("total_fs_count", 64'(fs_cnt), 64'(3));
    check_eq("latency_seen", 64'(lat_done), 64'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
